// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: opcode constants and FSM state type shared by the mc_alu slice.
package mc_alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mc_alu_iter.sv
// mc_alu_iter: one-bit-per-cycle datapath for signed Booth multiply and,
// when MC_ALU_DIV_EN is defined, signed restoring divide.
module mc_alu_iter
  import mc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic               run,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] res
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  // hi is one bit wider than the operand so Booth add/sub of the most
  // negative multiplicand cannot overflow the partial product.
  logic [WIDTH:0]     hi, hi_n, sum, m_ext;
  logic [WIDTH-1:0]   lo, lo_n, m;
  logic               qm1, qm1_n, mode_div;
  logic [CNT_W-1:0]   cnt;

`ifdef MC_ALU_DIV_EN
  logic [WIDTH:0]     shl, diff;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_q, neg_r;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`endif

  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign m_ext = {m[WIDTH-1], m};

  // One iteration step: Booth recode + arithmetic shift, or restoring subtract
  always_comb begin
    hi_n  = hi;
    lo_n  = lo;
    qm1_n = qm1;
    sum   = hi;
`ifdef MC_ALU_DIV_EN
    shl   = '0;
    diff  = '0;
`endif
    if (!mode_div) begin
      case ({lo[0], qm1})
        2'b01:   sum = hi + m_ext;
        2'b10:   sum = hi - m_ext;
        default: sum = hi;
      endcase
      {hi_n, lo_n, qm1_n} = {sum[WIDTH], sum, lo};
    end
`ifdef MC_ALU_DIV_EN
    else begin
      shl  = {hi[WIDTH-1:0], lo[WIDTH-1]};
      diff = shl - {1'b0, m};
      if (!diff[WIDTH]) begin
        hi_n = diff;
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shl;
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Final result as it will stand after the current step; sampled on the last one
  always_comb begin
    res = {hi_n[WIDTH-1:0], lo_n};
`ifdef MC_ALU_DIV_EN
    if (mode_div) begin
      res[WIDTH-1:0]       = neg_q ? -lo_n : lo_n;
      res[2*WIDTH-1:WIDTH] = neg_r ? -hi_n[WIDTH-1:0] : hi_n[WIDTH-1:0];
    end
`endif
  end

  // Operand load on start, then one step per cycle while running
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      qm1      <= 1'b0;
      cnt      <= '0;
      mode_div <= 1'b0;
`ifdef MC_ALU_DIV_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else if (load) begin
      hi       <= '0;
      qm1      <= 1'b0;
      cnt      <= '0;
      mode_div <= is_div;
`ifdef MC_ALU_DIV_EN
      // Divide works on magnitudes; signs are reapplied to the final result.
      lo       <= is_div ? a_mag : a;
      m        <= is_div ? b_mag : b;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r    <= a[WIDTH-1];
`else
      lo       <= a;
      m        <= b;
`endif
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      qm1 <= qm1_n;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU top. FSM, single-cycle ops and result registers.
// Optional signed divider enabled by defining MC_ALU_DIV_EN.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         op_select,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               dz
);

  state_t               state, state_n;
  logic                 go_iter, div_iter, accept;
  logic                 iter_last;
  logic [2*WIDTH-1:0]   iter_res;
  logic [WIDTH-1:0]     sc_lo, sc_hi;
  logic                 sc_dz;
  logic [SHAMT_W-1:0]   shamt;

  assign shamt  = b[SHAMT_W-1:0];
  assign accept = (state == IDLE) && start;

`ifdef MC_ALU_DIV_EN
  // Divide by zero bypasses the iterator and completes on the single-cycle path.
  assign div_iter = (op_select == OP_DIV) && (b != '0);
`else
  assign div_iter = 1'b0;
`endif
  assign go_iter = (op_select == OP_MUL) || div_iter;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and status outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = go_iter ? ITER : DONE;
      ITER: begin
        busy = 1'b1;
        if (iter_last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Single-cycle operations
  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    sc_dz = 1'b0;
    case (op_select)
      OP_ADD:  sc_lo = a + b;
      OP_SUB:  sc_lo = a - b;
      OP_SHR:  sc_lo = a >> shamt;
      OP_SHRA: sc_lo = $signed(a) >>> shamt;
      OP_SHL:  sc_lo = a << shamt;
      OP_ROR:  sc_lo = WIDTH'({a, a} >> shamt);
      OP_ROL:  sc_lo = WIDTH'(({a, a} << shamt) >> WIDTH);
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_NEG:  sc_lo = -b;
      OP_NOT:  sc_lo = ~a;
`ifdef MC_ALU_DIV_EN
      OP_DIV: begin
        sc_lo = '1;
        sc_hi = a;
        sc_dz = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Result and flag registers, updated only on the transition into DONE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      result <= '0;
      dz     <= 1'b0;
    end else if (accept && !go_iter) begin
      result <= {sc_hi, sc_lo};
      dz     <= sc_dz;
    end else if (state == ITER && iter_last) begin
      result <= iter_res;
      dz     <= 1'b0;
    end
  end

  mc_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .clr    (clr),
    .load   (accept && go_iter),
    .run    (state == ITER),
    .is_div (div_iter),
    .a      (a),
    .b      (b),
    .last   (iter_last),
    .res    (iter_res)
  );

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed vector table plus hand-written multi-cycle sequences.
module tb_mc_alu;
  import mc_alu_pkg::*;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic [4:0]     op_select;
  logic [W-1:0]   a, b;
  logic           busy, done, dz;
  logic [2*W-1:0] result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] res;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  mc_alu #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .op_select (op_select),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string n, input logic [4:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic [2*W-1:0] r, input logic z,
                                  input int l);
    vec_t v;
    v.name = n; v.op = op; v.a = x; v.b = y; v.res = r; v.dz = z; v.lat = l;
    vecs.push_back(v);
  endfunction

  // Launch one op, scramble the inputs after the start edge, wait for done.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] r, output logic z, output int lat,
                        output logic proto_ok);
    @(negedge clk);
    op_select = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; op_select = OP_SUB;
    lat = 1; proto_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) proto_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) proto_ok = 1'b0;
    r = result; z = dz;
    @(posedge clk); #1;
    if (done || busy) proto_ok = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*W-1:0] r;
    logic           z, ok;
    int             lat, cyc, ndone;

    add_vec("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'h1,        64'h0,                   1'b0, 1);
    add_vec("add",      OP_ADD,  32'h2,        32'h3,        64'h5,                   1'b0, 1);
    add_vec("sub",      OP_SUB,  32'h5,        32'h7,        64'h00000000FFFFFFFE,    1'b0, 1);
    add_vec("shr",      OP_SHR,  32'h80000000, 32'h4,        64'h08000000,            1'b0, 1);
    add_vec("shra",     OP_SHRA, 32'h80000000, 32'h4,        64'hF8000000,            1'b0, 1);
    add_vec("shra0",    OP_SHRA, 32'h80000000, 32'h20,       64'h80000000,            1'b0, 1);
    add_vec("shl",      OP_SHL,  32'h1,        32'd31,       64'h80000000,            1'b0, 1);
    add_vec("ror",      OP_ROR,  32'h1,        32'h1,        64'h80000000,            1'b0, 1);
    add_vec("rol",      OP_ROL,  32'h80000001, 32'h1,        64'h3,                   1'b0, 1);
    add_vec("and",      OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 64'h00F000F0,            1'b0, 1);
    add_vec("or",       OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 64'hFFFFF0F0,            1'b0, 1);
    add_vec("neg",      OP_NEG,  32'h1234,     32'h1,        64'h00000000FFFFFFFF,    1'b0, 1);
    add_vec("not",      OP_NOT,  32'h0000FFFF, 32'h5,        64'hFFFF0000,            1'b0, 1);
    add_vec("bad0",     5'b00000, 32'h7,       32'h9,        64'h0,                   1'b0, 1);
    add_vec("bad31",    5'b11111, 32'h7,       32'h9,        64'h0,                   1'b0, 1);
    add_vec("mul",      OP_MUL,  32'hFFFFFFFD, 32'h7,        64'hFFFFFFFFFFFFFFEB,    1'b0, 33);
    add_vec("mul_min",  OP_MUL,  32'h80000000, 32'h80000000, 64'h4000000000000000,    1'b0, 33);
    add_vec("mul_m1",   OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1,                   1'b0, 33);
    add_vec("mul_pos",  OP_MUL,  32'h7FFFFFFF, 32'h2,        64'h00000000FFFFFFFE,    1'b0, 33);
`ifdef MC_ALU_DIV_EN
    add_vec("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'h2,        64'hFFFFFFFFFFFFFFFD,    1'b0, 33);
    add_vec("div_zero", OP_DIV,  32'h5,        32'h0,        64'h00000005FFFFFFFF,    1'b1, 1);
    add_vec("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000,    1'b0, 33);
    add_vec("div_pos",  OP_DIV,  32'd100,      32'd7,        64'h000000020000000E,    1'b0, 33);
`else
    add_vec("div_off",  OP_DIV,  32'd100,      32'd7,        64'h0,                   1'b0, 1);
    add_vec("div_off0", OP_DIV,  32'h5,        32'h0,        64'h0,                   1'b0, 1);
`endif

    clr = 1'b1; start = 1'b0; op_select = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", result, 64'h0);
    check("rst_dz", 64'(dz), 64'(0));
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, ok);
      check({vecs[i].name, "_res"}, r, vecs[i].res);
      check({vecs[i].name, "_dz"}, 64'(z), 64'(vecs[i].dz));
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_proto"}, 64'(ok), 64'(1));
    end

    // mul with a competing start pulse in cycle 5
    @(negedge clk);
    op_select = OP_MUL; a = 32'hFFFFFFFD; b = 32'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start = 1'b1; op_select = OP_ADD; a = 32'h2; b = 32'h3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("busy_ign_lat", 64'(cyc), 64'(33));
    check("busy_ign_res", result, 64'hFFFFFFFFFFFFFFEB);
    @(posedge clk); #1;
    check("busy_ign_idle", 64'(busy), 64'(0));

    // start held through the DONE cycle must not launch a second op
    @(negedge clk);
    op_select = OP_ADD; a = 32'h2; b = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    op_select = OP_SUB; a = 32'h9; b = 32'h1;
    check("done_cyc_done", 64'(done), 64'(1));
    @(posedge clk); #1;
    start = 1'b0;
    check("done_cyc_busy", 64'(busy), 64'(0));
    check("done_cyc_nodone", 64'(done), 64'(0));
    check("done_cyc_res", result, 64'h5);
    @(posedge clk); #1;
    check("done_cyc_still_idle", 64'(busy), 64'(0));

    // clr in cycle 10 of a mul aborts it
    @(negedge clk);
    op_select = OP_MUL; a = 32'hFFFFFFFD; b = 32'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'(0));
    check("clr_done", 64'(done), 64'(0));
    check("clr_result", result, 64'h0);
    check("clr_dz", 64'(dz), 64'(0));
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("clr_no_done", 64'(ndone), 64'(0));
    run_op(OP_ADD, 32'h2, 32'h3, r, z, lat, ok);
    check("post_clr_res", r, 64'h5);
    check("post_clr_lat", 64'(lat), 64'(1));
    check("post_clr_proto", 64'(ok), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width, legal range 8..64.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift/rotate amount width taken from b[SHAMT_W-1:0].
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op_select  input  5  operation code, sampled with start.
REQ-007 SHALL have ports a and b  input  WIDTH each  operands, sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-010 SHALL have port result  output  2*WIDTH  registered result, held until the next done.
REQ-011 SHALL have port dz  output  1  divide-by-zero flag, valid with done and held until the next done.

Function
REQ-012 SHALL use these codes: 00011 add, 00100 sub, 00101 shr, 00110 shra, 00111 shl, 01000 ror, 01001 rol, 01010 and, 01011 or, 01111 mul, 10000 div, 10001 neg (of b), 10010 not (of a); all other codes SHALL produce result 0.
REQ-013 SHALL implement states IDLE, ITER and DONE: IDLE -> DONE for single-cycle ops; IDLE -> ITER for mul and div; ITER -> DONE after WIDTH iterations; DONE -> IDLE unconditionally.
REQ-014 Single-cycle ops SHALL assert done exactly 1 cycle after the start edge.
REQ-015 Mul and div SHALL assert done exactly WIDTH+1 cycles after the start edge.
REQ-016 busy SHALL be high from the cycle after the start edge up to and including the done cycle.
REQ-017 start SHALL be ignored while busy is high; the operation in progress SHALL be unaffected.
REQ-018 start in the DONE cycle SHALL be ignored; a new operation SHALL be accepted from IDLE only.
REQ-019 Operands and opcode SHALL be captured at start; later input changes SHALL NOT affect the result.
REQ-020 Add, sub and neg SHALL be modulo 2^WIDTH, with result[WIDTH-1:0] holding the value and the upper half 0.
REQ-021 Logic, shift and rotate results SHALL occupy result[WIDTH-1:0] with the upper half 0.
REQ-022 shra SHALL sign-fill; a shift amount of 0 SHALL return a unchanged.
REQ-023 mul SHALL be signed radix-2 Booth, one bit per cycle, giving the full 2*WIDTH product.
REQ-024 div SHALL be signed: quotient in result[WIDTH-1:0] truncated toward zero, remainder in result[2*WIDTH-1:WIDTH] with the sign of the dividend.
REQ-025 div with b==0 SHALL complete via the single-cycle path with quotient all ones, remainder a, and dz=1.
REQ-026 div of the most negative value by -1 SHALL return quotient equal to the most negative value, remainder 0, and dz=0.

Reset
REQ-027 clr SHALL force IDLE with busy=0, done=0, result=0 and dz=0, regardless of clk.
REQ-028 clr asserted mid-ITER SHALL abort the operation with no done pulse, and the first start after release SHALL behave normally.

Configuration
REQ-029 With MC_ALU_DIV_EN defined, div SHALL be as in REQ-024 to REQ-026.
REQ-030 Without MC_ALU_DIV_EN, code 10000 SHALL complete single-cycle with result 0 and dz=0, and no divider logic SHALL be synthesised.

Structure
REQ-031 Package mc_alu_pkg SHALL hold the opcode constants and the state enum typedef.
REQ-032 The iterative mul/div datapath (shift registers and iteration counter) SHALL be sub-module mc_alu_iter; mc_alu SHALL hold the FSM and the single-cycle ops.

Verification (WIDTH=32)
REQ-033 add with a=0xFFFFFFFF, b=1 -> result 0 and done exactly 1 cycle after start.
REQ-034 mul with a=-3, b=7 -> result 0xFFFFFFFFFFFFFFEB with done at cycle 33; a start issued at cycle 5 is ignored.
REQ-035 div with a=-7, b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, dz=0 at cycle 33.
REQ-036 div with a=5, b=0 -> quotient 0xFFFFFFFF, remainder 5, dz=1, done at cycle 1.
REQ-037 shra with a=0x80000000, b=4 -> 0xF8000000; rol with a=0x80000001, b=1 -> 0x00000003.
REQ-038 clr at cycle 10 of a mul -> no done pulse, and a following add with a=2, b=3 -> result 5.
